// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared defaults and next-PC select encoding for the fetch stage
// Purpose: XLEN / INSTR_BYTES / RESET_VECTOR defaults and the next-PC source encoding.
// Ports:   none (package).
package riscv_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam int          INSTR_BYTES_DEF  = 4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

  // Next-PC source, listed in priority order.
  typedef enum logic [2:0] {
    SEL_TRAP  = 3'd0,
    SEL_REDIR = 3'd1,
    SEL_HOLD  = 3'd2,
    SEL_RAS   = 3'd3,
    SEL_SEQ   = 3'd4
  } next_pc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control/status bundle between fetch control and the PC stage
// Purpose: groups the PC-stage control inputs and status outputs.
// Ports:   master = fetch control side (drives stall/redirect/trap/hints),
//          slave  = pc_unit (drives pc_out, ras_hit, misalign_err, fetch_count).
interface pc_unit_if
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 32
) ();

  logic             stall;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_target;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_vector;
  logic             call_hint;
  logic             ret_hint;
  logic [XLEN-1:0]  pc_out;
  logic             ras_hit;
  logic             misalign_err;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output stall, redirect_valid, redirect_target, trap_valid, trap_vector,
           call_hint, ret_hint,
    input  pc_out, ras_hit, misalign_err, fetch_count
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap_valid, trap_vector,
           call_hint, ret_hint,
    output pc_out, ras_hit, misalign_err, fetch_count
  );

endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with saturating occupancy count
// Purpose: call/return prediction storage; a push when full overwrites the oldest entry.
// Ports:   clk, reset (async, active-high), flush (count<=0), push, pop,
//          push_data (return address), top (entry at ptr-1), empty (count==0).
//          push and pop together replace the top entry in place (coroutine swap).
module pc_ras
  import riscv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int OCC_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_m1;
  logic [OCC_W-1:0] count;
  logic             do_pop;
  logic             do_swap;

  assign ptr_m1  = ptr - PTR_W'(1);
  assign top     = mem[ptr_m1];
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_swap = push && do_pop;

  // Pointer wraps naturally because RAS_DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (do_swap) begin
      ptr   <= ptr;
      count <= count;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (count != OCC_W'(RAS_DEPTH)) count <= count + OCC_W'(1);
    end else if (do_pop) begin
      ptr   <= ptr_m1;
      count <= count - OCC_W'(1);
    end
  end

  // Storage needs no reset: occupancy count guards every read.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      if (do_swap) mem[ptr_m1] <= push_data;
      else         mem[ptr]    <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program-counter stage with next-PC select, RAS and fetch counter
// Purpose: holds the fetch PC; next PC from trap > redirect > stall > RAS return > sequential.
// Ports:   clk, reset (async, active-high), bus (pc_unit_if.slave):
//          in  stall, redirect_valid/target, trap_valid/vector, call_hint, ret_hint
//          out pc_out, ras_hit, misalign_err (1-cycle pulse), fetch_count
module pc_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int              INSTR_BYTES  = INSTR_BYTES_DEF,
  parameter int              RAS_DEPTH    = 4,
  parameter int              CNT_W        = 32
) (
  input  logic       clk,
  input  logic       reset,
  pc_unit_if.slave   bus
);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_next;
  logic [XLEN-1:0]  pc_seq;
  logic [XLEN-1:0]  ras_top;
  logic             ras_empty;
  logic             ras_hit_q;
  logic             misalign_q;
  logic [CNT_W-1:0] count_q;
  logic             misaligned;
  logic             hints_live;
  next_pc_sel_e     sel;

  assign pc_seq     = pc_q + XLEN'(INSTR_BYTES);
  assign misaligned = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
  // Hints only matter on edges that fall through to RAS/sequential selection.
  assign hints_live = (sel == SEL_RAS) || (sel == SEL_SEQ);

  always_comb begin
    sel     = SEL_SEQ;
    pc_next = pc_seq;
    if (bus.trap_valid) begin
      sel     = SEL_TRAP;
      pc_next = bus.trap_vector;
    end else if (bus.redirect_valid) begin
      sel     = misaligned ? SEL_HOLD : SEL_REDIR;
      pc_next = misaligned ? pc_q : bus.redirect_target;
    end else if (bus.stall) begin
      sel     = SEL_HOLD;
      pc_next = pc_q;
    end else if (bus.ret_hint && !ras_empty) begin
      sel     = SEL_RAS;
      pc_next = ras_top;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .flush     (sel == SEL_TRAP),
    .push      (hints_live && bus.call_hint),
    .pop       (sel == SEL_RAS),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      ras_hit_q  <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_next;
      // A trap overrides a misaligned redirect, so no error on trap edges.
      misalign_q <= misaligned && !bus.trap_valid;
      // ras_hit describes the last advance, so held edges keep it.
      if (sel != SEL_HOLD) begin
        ras_hit_q <= (sel == SEL_RAS);
        count_q   <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.ras_hit      = ras_hit_q;
  assign bus.misalign_err = misalign_q;
  assign bus.fetch_count  = count_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard testbench for pc_unit
module tb_pc_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0),
    .INSTR_BYTES  (4),
    .RAS_DEPTH    (4),
    .CNT_W        (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] m_pc;
  logic        m_hit;
  logic [31:0] m_cnt;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_hit = 1'b0;
    m_cnt = 32'h0;
    m_ras.delete();
    sb.delete();
  endtask

  // Drive one cycle, predict the outcome, compare after the edge.
  task automatic drive(input logic st, input logic rv, input logic [31:0] rt,
                       input logic tv, input logic [31:0] tvec,
                       input logic ch, input logic rh);
    exp_t e;
    exp_t got;
    logic [31:0] ret_addr;
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.trap_valid      = tv;
    bus.trap_vector     = tvec;
    bus.call_hint       = ch;
    bus.ret_hint        = rh;
    e.mis = 1'b0;
    if (tv) begin
      m_pc = tvec; m_hit = 1'b0; m_cnt++; m_ras.delete();
    end else if (rv && rt[1:0] == 2'b00) begin
      m_pc = rt; m_hit = 1'b0; m_cnt++;
    end else if (rv) begin
      e.mis = 1'b1;
    end else if (st) begin
      // hold everything
    end else begin
      ret_addr = m_pc + 32'd4;
      if (rh && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back(); m_hit = 1'b1;
      end else begin
        m_pc = ret_addr; m_hit = 1'b0;
      end
      if (ch) begin
        m_ras.push_back(ret_addr);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      m_cnt++;
    end
    e.pc = m_pc; e.hit = m_hit; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("pc_out", bus.pc_out, got.pc);
    check("ras_hit", bus.ras_hit, got.hit);
    check("misalign_err", bus.misalign_err, got.mis);
    check("fetch_count", bus.fetch_count, got.cnt);
  endtask

  task automatic free_step();
    drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_target = 0;
    bus.trap_valid = 0; bus.trap_vector = 0; bus.call_hint = 0; bus.ret_hint = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", bus.pc_out, 32'h0);
    check("rst_cnt", bus.fetch_count, 32'h0);
    check("rst_hit", bus.ras_hit, 1'b0);
    check("rst_mis", bus.misalign_err, 1'b0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    // T1 reset then 3 free cycles
    do_reset();
    repeat (3) free_step();
    check("t1_pc", bus.pc_out, 32'hC);
    check("t1_cnt", bus.fetch_count, 32'd3);

    // T2 trap beats redirect; trap flushes RAS
    drive(0, 0, 0, 0, 0, 1, 0);                    // call pushes 0x10
    drive(0, 1, 32'h100, 1, 32'h80, 0, 0);
    check("t2_trap_pc", bus.pc_out, 32'h80);
    drive(0, 0, 0, 0, 0, 0, 1);                    // ret on flushed RAS
    check("t2_seq_pc", bus.pc_out, 32'h84);

    // T3 call / ret / ret-empty
    drive(0, 1, 32'h10, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    check("t3_call_pc", bus.pc_out, 32'h14);
    drive(0, 1, 32'h200, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    check("t3_ret_pc", bus.pc_out, 32'h14);
    check("t3_ret_hit", bus.ras_hit, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check("t3_empty_pc", bus.pc_out, 32'h18);

    // T4 overflow: 5 calls from 0x0, 5 returns
    drive(0, 1, 32'h0, 0, 0, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    check("t4_ret0", bus.pc_out, 32'h14);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 1);
    check("t4_ret3", bus.pc_out, 32'h8);
    drive(0, 0, 0, 0, 0, 0, 1);
    check("t4_ret4_seq", bus.pc_out, 32'hC);
    check("t4_ret4_hit", bus.ras_hit, 1'b0);

    // Coroutine swap: call at 0x40, then call+ret at 0x300
    drive(0, 1, 32'h40, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);                    // push 0x44
    drive(0, 1, 32'h300, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1);                    // pc<=0x44, slot<=0x304
    check("swap_pc", bus.pc_out, 32'h44);
    drive(0, 0, 0, 0, 0, 0, 1);
    check("swap_ret", bus.pc_out, 32'h304);

    // T5 misaligned redirect, then stalls with hints ignored
    drive(0, 1, 32'h102, 0, 0, 0, 0);
    check("t5_mis", bus.misalign_err, 1'b1);
    free_step();
    check("t5_mis_clear", bus.misalign_err, 1'b0);
    drive(1, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);                    // RAS still empty -> sequential
    drive(1, 1, 32'h103, 1, 32'h500, 0, 0);        // trap overrides misaligned redirect
    check("trap_over_mis", bus.pc_out, 32'h500);

    // T6 wrap, then async reset between edges
    drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    free_step();
    check("t6_wrap", bus.pc_out, 32'h0);
    free_step();
    reset = 1'b1;
    #2;
    check("t6_async_pc", bus.pc_out, 32'h0);
    check("t6_async_cnt", bus.fetch_count, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (2) free_step();
    check("post_rst_pc", bus.pc_out, 32'h8);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
